// File: rtl/mips_pkg.sv
// Shared types for the MIPS program loader: command codes, header layout
// and the loader state encoding.
package mips_pkg;

  localparam logic [1:0] CMD_IMEM = 2'b00;
  localparam logic [1:0] CMD_DMEM = 2'b01;
  localparam logic [1:0] CMD_GO   = 2'b10;
  localparam logic [1:0] CMD_RSVD = 2'b11;

  localparam int HDR_CMD_LSB  = 30;
  localparam int HDR_CMD_W    = 2;
  localparam int HDR_BASE_LSB = 16;
  localparam int HDR_BASE_W   = 14;
  localparam int HDR_CNT_LSB  = 0;
  localparam int HDR_CNT_W    = 16;

  typedef struct packed {
    logic [HDR_CMD_W-1:0]  cmd;
    logic [HDR_BASE_W-1:0] base;
    logic [HDR_CNT_W-1:0]  cnt;
  } hdr_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } ldr_state_e;

  function automatic hdr_t hdr_decode(
    input logic [31:0] w
  );
    hdr_t h;
    h.cmd  = w[HDR_CMD_LSB  +: HDR_CMD_W];
    h.base = w[HDR_BASE_LSB +: HDR_BASE_W];
    h.cnt  = w[HDR_CNT_LSB  +: HDR_CNT_W];
    return h;
  endfunction

endpackage

// File: rtl/mips_loader_timer.sv
// Run-window timer: counts down the cycles the core is released and
// accumulates the total number of released cycles.
module mips_loader_timer #(
  parameter int RUN_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        start,
  input  logic        run,
  output logic        expired,
  output logic [31:0] cycle_count
);

  logic [31:0] rem_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      rem_q       <= '0;
      cycle_count <= '0;
    end else begin
      // remaining cycles after the current one; zero marks the last
      if (start)
        rem_q <= 32'(RUN_CYCLES - 1);
      else if (run && rem_q != '0)
        rem_q <= rem_q - 32'd1;
      if (run)
        cycle_count <= cycle_count + 32'd1;
    end
  end

  assign expired = run && (rem_q == '0);

endmodule

// File: rtl/mips_program_loader.sv
// Stream-driven memory loader and run controller for the MIPS core.
// Define MIPS_LOADER_DMEM_INIT_EN to fill dmem[i]=i after every reset.
module mips_program_loader
  import mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64,
  parameter int RUN_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  output logic                          imem_we,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  output logic                          dmem_we,
  output logic [$clog2(DMEM_DEPTH)-1:0] dmem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          cpu_rst,
  output logic [31:0]                   cycle_count,
  output logic                          done,
  output logic                          err
);

  localparam int IA = $clog2(IMEM_DEPTH);
  localparam int DA = $clog2(DMEM_DEPTH);
  // wide enough for base + count without wrapping
  localparam int AW = 18;

`ifdef MIPS_LOADER_DMEM_INIT_EN
  localparam ldr_state_e RST_ST = ST_INIT;
`else
  localparam ldr_state_e RST_ST = ST_IDLE;
`endif

  ldr_state_e      state_q;
  ldr_state_e      state_d;
  hdr_t            hdr;
  logic [AW-1:0]   addr_q;
  logic [15:0]     left_q;
  logic            tgt_dmem_q;
  logic            accept;
  logic            wr_ok;
  logic            t_start;
  logic            t_run;
  logic            expired;

`ifdef MIPS_LOADER_DMEM_INIT_EN
  logic [DA-1:0]   init_q;
  logic            init_last;
  assign init_last = (init_q == DA'(DMEM_DEPTH - 1));
`endif

  assign hdr    = hdr_decode(in_data[31:0]);
  assign accept = in_valid && in_ready;

  assign wr_ok = tgt_dmem_q ? (addr_q < AW'(DMEM_DEPTH))
                            : (addr_q < AW'(IMEM_DEPTH));

  assign t_start = accept && (state_q == ST_IDLE)
                   && (hdr.cmd == CMD_GO);
  assign t_run   = (state_q == ST_RUN);

  mips_loader_timer #(
    .RUN_CYCLES(RUN_CYCLES)
  ) u_timer (
    .clk        (clk),
    .clear      (rst),
    .start      (t_start),
    .run        (t_run),
    .expired    (expired),
    .cycle_count(cycle_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= RST_ST;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    cpu_rst  = 1'b1;
    done     = 1'b0;
    unique case (state_q)
      ST_INIT: begin
`ifdef MIPS_LOADER_DMEM_INIT_EN
        if (init_last) state_d = ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          unique case (1'b1)
            (hdr.cmd == CMD_GO):   state_d = ST_RUN;
            (hdr.cmd == CMD_RSVD): state_d = ST_IDLE;
            default:
              if (hdr.cnt != '0) state_d = ST_LOAD;
          endcase
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && left_q == 16'd1)
          state_d = ST_IDLE;
      end
      ST_RUN: begin
        cpu_rst = 1'b0;
        if (expired) state_d = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: state_d = RST_ST;
    endcase
    if (rst) begin
      in_ready = 1'b0;
      cpu_rst  = 1'b1;
      done     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imem_we    <= 1'b0;
      dmem_we    <= 1'b0;
      imem_addr  <= '0;
      dmem_addr  <= '0;
      mem_wdata  <= '0;
      err        <= 1'b0;
      addr_q     <= '0;
      left_q     <= '0;
      tgt_dmem_q <= 1'b0;
`ifdef MIPS_LOADER_DMEM_INIT_EN
      init_q     <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      dmem_we <= 1'b0;
`ifdef MIPS_LOADER_DMEM_INIT_EN
      if (state_q == ST_INIT) begin
        dmem_we   <= 1'b1;
        dmem_addr <= init_q;
        mem_wdata <= DATA_W'(init_q);
        init_q    <= init_q + DA'(1);
      end
`endif
      if (accept && state_q == ST_IDLE) begin
        addr_q     <= AW'(hdr.base);
        left_q     <= hdr.cnt;
        tgt_dmem_q <= (hdr.cmd == CMD_DMEM);
        if (hdr.cmd == CMD_RSVD) err <= 1'b1;
      end
      if (accept && state_q == ST_LOAD) begin
        addr_q <= addr_q + AW'(1);
        left_q <= left_q - 16'd1;
        // out-of-range words are swallowed without a strobe
        if (wr_ok) begin
          mem_wdata <= in_data;
          if (tgt_dmem_q) begin
            dmem_we   <= 1'b1;
            dmem_addr <= addr_q[DA-1:0];
          end else begin
            imem_we   <= 1'b1;
            imem_addr <= addr_q[IA-1:0];
          end
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/mips_program_loader.md
# mips_program_loader

Boot and run controller for the single-cycle MIPS core, replacing hard-coded bench memory preloads with a reusable, parametrised block. It accepts a valid/ready word stream of commands and payload, writes the payload into the instruction or data memory write port, and holds the core in reset until told to run. It then runs the core for a bounded number of cycles and flags completion. It sits between a host or bench stream source and the core's `clk`/`rst` domain.

## Interface
- `DATA_W`, 32: memory word width; also the stream width; must be at least 32.
- `IMEM_DEPTH`, 64: instruction memory words.
- `DMEM_DEPTH`, 64: data memory words.
- `RUN_CYCLES`, 1000: number of cycles the core is released per GO; must be at least 1.
- `clk` in 1: single clock.
- `rst` in 1: reset; synchronous, active-high.
- `in_valid` in 1: stream word valid.
- `in_data` in DATA_W: stream word.
- `in_ready` out 1: loader accepts the word this cycle.
- `imem_we` out 1: instruction memory write strobe.
- `imem_addr` out $clog2(IMEM_DEPTH): instruction memory write address.
- `dmem_we` out 1: data memory write strobe.
- `dmem_addr` out $clog2(DMEM_DEPTH): data memory write address.
- `mem_wdata` out DATA_W: write data; shared by both memories.
- `cpu_rst` out 1: reset to the core; active-high.
- `cycle_count` out 32: count of cycles with `cpu_rst` low since `rst`.
- `done` out 1: run finished; sticky.
- `err` out 1: protocol or range error; sticky.

## Operation
- **Handshake.** A word transfers on a cycle where `in_valid && in_ready` is true.
- **Header format.** `[31:30]` command, `[29:16]` base address, `[15:0]` count N. Command encodings:
  - 00: IMEM load.
  - 01: DMEM load.
  - 10: GO.
  - 11: reserved.
- **States.** The FSM has states INIT, IDLE, LOAD, RUN and DONE.
- **IDLE.** `in_ready`=1.
  - Header with N>0 → LOAD; address counter is set to base.
  - Load header with N=0 → stays in IDLE.
  - GO → RUN.
  - Reserved command → `err`=1; stays in IDLE.
- **LOAD.** `in_ready`=1.
  - Each payload word is written at the counter address, then the counter increments.
  - After the Nth word the FSM returns to IDLE.
  - If an address is at or above the target memory's depth, the word is consumed but not written, and `err`=1. Addresses never wrap.
- **RUN.**
  - `in_ready`=0 and `cpu_rst`=0.
  - `cycle_count` increments every RUN cycle.
  - After exactly RUN_CYCLES cycles → DONE.
- **DONE.** `cpu_rst`=1, `done`=1 and `in_ready`=0. The FSM stays in DONE until `rst`.
- **Reset mid-operation.** `rst` has priority in every state:
  - next state is IDLE, or INIT when it is compiled in;
  - all flags and counters clear and `cpu_rst`=1;
  - memory contents already written are not cleared;
  - a partially received payload is discarded.

## Timing
- **Reset values.**
  - `cpu_rst`=1.
  - `in_ready`, `imem_we`, `dmem_we`, `done` and `err` are 0.
  - Addresses, `mem_wdata` and `cycle_count` are 0.
- **Write latency.** Write strobe, address and data are registered and appear 1 cycle after the payload handshake. The strobe is a single-cycle pulse.
- **Throughput.** One payload word per cycle. The header costs 1 cycle with no write.
- **GO.**
  - GO handshake at cycle t → `cpu_rst` falls at t+1.
  - `cpu_rst` stays low for exactly RUN_CYCLES cycles.
  - `cpu_rst` rises in the same cycle that `done` rises.
- **Error timing.** `err` is set 1 cycle after the offending handshake.

## Configuration
- **Macro:** `MIPS_LOADER_DMEM_INIT_EN`.
- **Defined.**
  - After `rst` deasserts, the FSM is in INIT.
  - It writes dmem[i]=i for i=0…DMEM_DEPTH-1, one word per cycle, with `in_ready`=0.
  - It then goes to IDLE, so IDLE is reached DMEM_DEPTH cycles after reset.
- **Undefined.**
  - The INIT state is absent; the FSM leaves reset directly in IDLE.
  - Data memory is written only by stream commands.

## Structure
- **Shared package `mips_pkg`:**
  - command encodings `CMD_IMEM`, `CMD_DMEM`, `CMD_GO`, `CMD_RSVD`;
  - header field bit positions;
  - the loader state enum typedef.
- **Sub-module `mips_loader_timer`:** run-cycle down-counter plus the 32-bit `cycle_count`, with inputs start and clear and output expired.
- **Top level:** the FSM, header decode, address counter and write-port registers.

## Test plan
- **IMEM load.** Header {00, base 0, N 3}, then words A, B, C with `in_valid` held high → `imem_we` pulses on 3 consecutive cycles at addresses 0, 1, 2 with data A, B, C; `err`=0.
- **DMEM out of range.** DMEM header with base 62 and N 4 → writes at 62 and 63 only; all 4 words are accepted; `err`=1; state returns to IDLE.
- **GO with RUN_CYCLES=10.** GO at cycle t → `cpu_rst` is low for cycles t+1 through t+10; `done`=1 at t+11; `cycle_count`=10; `in_ready`=0 afterwards.
- **Stalls and reserved command.** `in_valid` gaps inside a payload → no spurious writes. Reserved command header → `err`=1; `in_ready` stays 1.
- **Reset mid-load.** `rst` asserted after 2 of 5 payload words → next cycle in IDLE with `cpu_rst`=1 and `err`=0. A new header is then accepted normally.
- **INIT fill (macro defined).** With DMEM_DEPTH=64 → 64 `dmem_we` pulses with addr=data=0…63, then `in_ready`=1.
